// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, I2C register address map and
// a saturating increment helper. Also imported by the I2C APB slave.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam logic [31:0] ADDR_CFG  = 32'h0000_0000;
    localparam logic [31:0] ADDR_DIN  = 32'h0000_0004;
    localparam logic [31:0] ADDR_DOUT = 32'h0000_0008;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating 16-bit wait-state counter. o_tc flags that the count has
// reached TIMEOUT-1, i.e. the current wait cycle is the last one allowed.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [15:0] TC_VALUE = 16'(TIMEOUT - 1);

    logic [15:0] r_count;

    // Counter: clear has priority over enable, never wraps
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= 16'h0000;
        end else if (i_clr) begin
            r_count <= 16'h0000;
        end else if (i_en) begin
            r_count <= sat_inc16(r_count);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_tc = (r_count == TC_VALUE);

endmodule

// File: rtl/apb_master.sv
// APB initiator: turns single host read/write commands into SETUP/ACCESS
// transfers with a bounded ACCESS phase, and returns data and error status.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWrite,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_state_e        r_state;
    logic              r_cmd_ready;
    logic              r_busy;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_rsp_timeout;

    logic w_accept;
    logic w_wait;
    logic w_tc;

    assign w_accept = (r_state == ST_IDLE) && cmd_valid;
    assign w_wait   = (r_state == ST_ACCESS) && !PREADY;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .i_clk (PCLK),
        .i_rst (PRESET),
        .i_clr (w_accept),
        .i_en  (w_wait),
        .o_tc  (w_tc)
    );

    // Transfer FSM with all APB and response outputs registered
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state       <= ST_IDLE;
            r_cmd_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= {ADDR_W{1'b0}};
            r_pwdata      <= {DATA_W{1'b0}};
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= {DATA_W{1'b0}};
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_state     <= ST_SETUP;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_psel      <= 1'b1;
                        r_pwrite    <= cmd_write;
                        r_paddr     <= cmd_addr;
                        r_pwdata    <= cmd_wdata;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    r_state   <= ST_ACCESS;
                    r_penable <= 1'b1;
                end
                ST_ACCESS: begin
                    // PREADY beats the timeout when both land in one cycle
                    if (PREADY) begin
                        r_state       <= ST_IDLE;
                        r_cmd_ready   <= 1'b1;
                        r_busy        <= 1'b0;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= r_pwrite ? {DATA_W{1'b0}} : PRDATA;
                        r_rsp_err     <= PSLVERR;
                        r_rsp_timeout <= 1'b0;
                    end else if (w_tc) begin
                        r_state       <= ST_IDLE;
                        r_cmd_ready   <= 1'b1;
                        r_busy        <= 1'b0;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= {DATA_W{1'b0}};
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                    end else begin
                        r_state <= ST_ACCESS;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_psel      <= 1'b0;
                    r_penable   <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign busy        = r_busy;
    assign PSEL        = r_psel;
    assign PENABLE     = r_penable;
    assign PWrite      = r_pwrite;
    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: vector table of single transfers with a
// behavioural APB slave, a response scoreboard, plus back-to-back and reset cases.
module tb_apb_master;
    import apb_pkg::*;

    localparam int unsigned TMO = 4;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'h0;
    logic [31:0] cmd_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        busy;
    logic        PSEL, PENABLE, PWrite;
    logic [31:0] PADDR, PWDATA;
    logic [31:0] PRDATA = 32'h0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;

    apb_master #(.TIMEOUT(TMO), .ADDR_W(32), .DATA_W(32)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWrite(PWrite), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          waits;
        logic        slverr;
        logic [31:0] e_rdata;
        logic        e_err;
        logic        e_to;
        int          e_lat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;

    vec_t        vecs[6];
    rsp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cur_waits = 0;
    logic [31:0] cur_prdata = 32'h0;
    logic        cur_slverr = 1'b0;
    int          wcnt = 0;
    logic [31:0] lat_addr, lat_wdata;
    logic        lat_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave model: PREADY after cur_waits wait states, address-phase stability check
    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            if (wcnt == 0) begin
                lat_addr  = PADDR;
                lat_wdata = PWDATA;
                lat_wr    = PWrite;
            end else begin
                chk("access_paddr_stable", PADDR, lat_addr);
                chk("access_pwdata_stable", PWDATA, lat_wdata);
                chk("access_pwrite_stable", {31'd0, PWrite}, {31'd0, lat_wr});
            end
            PREADY  = (wcnt == cur_waits);
            PSLVERR = cur_slverr && (wcnt == cur_waits);
            PRDATA  = cur_prdata;
            wcnt++;
        end else begin
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            wcnt    = 0;
        end
    end

    // Scoreboard: every rsp_valid pulse must match the oldest expected response
    always @(negedge PCLK) begin
        if (!PRESET && rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response at %0t", $time);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.to});
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 40) begin
            @(negedge PCLK);
            n++;
        end
        chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic wait_rsp(output int k);
        k = 1;
        while (!rsp_valid && k < 40) begin
            @(negedge PCLK);
            k++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int k;
        wait_ready();
        cur_waits  = v.waits;
        cur_prdata = v.prdata;
        cur_slverr = v.slverr;
        sb.push_back('{v.e_rdata, v.e_err, v.e_to});
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        chk("setup_psel", {31'd0, PSEL}, 32'd1);
        chk("setup_penable", {31'd0, PENABLE}, 32'd0);
        chk("setup_paddr", PADDR, v.addr);
        chk("setup_pwdata", PWDATA, v.wdata);
        chk("setup_busy", {31'd0, busy}, 32'd1);
        wait_rsp(k);
        chk("rsp_latency", k, v.e_lat);
        chk("done_psel_low", {31'd0, PSEL}, 32'd0);
        chk("done_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        int k;
        //          wr    addr       wdata         prdata        waits slverr e_rdata       err   to    lat
        vecs[0] = '{1'b1, ADDR_CFG,  32'h0000_0203, 32'h1111_1111, 0,   1'b0, 32'h0,        1'b0, 1'b0, 3};
        vecs[1] = '{1'b0, ADDR_DOUT, 32'h0,         32'hDEAD_BEEF, 2,   1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 5};
        vecs[2] = '{1'b1, ADDR_DIN,  32'h0000_0055, 32'h2222_2222, 0,   1'b1, 32'h0,        1'b1, 1'b0, 3};
        vecs[3] = '{1'b0, ADDR_CFG,  32'h0,         32'h3333_3333, 100, 1'b0, 32'h0,        1'b1, 1'b1, 6};
        vecs[4] = '{1'b0, ADDR_DOUT, 32'h0,         32'h1234_5678, 3,   1'b0, 32'h1234_5678, 1'b0, 1'b0, 6};
        vecs[5] = '{1'b0, ADDR_CFG,  32'h0,         32'h0000_A5A5, 1,   1'b1, 32'h0000_A5A5, 1'b1, 1'b0, 4};

        repeat (3) @(negedge PCLK);
        chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("reset_psel", {31'd0, PSEL}, 32'd0);
        chk("reset_penable", {31'd0, PENABLE}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_paddr", PADDR, 32'h0);
        PRESET = 1'b0;
        @(negedge PCLK);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Back-to-back: cmd_valid held, second SETUP one cycle after first rsp_valid
        @(negedge PCLK);
        cur_waits  = 1;
        cur_prdata = 32'hCAFE_0001;
        cur_slverr = 1'b0;
        sb.push_back('{32'h0, 1'b0, 1'b0});
        sb.push_back('{32'hCAFE_0001, 1'b0, 1'b0});
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = ADDR_DIN;
        cmd_wdata = 32'h0000_00AA;
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_write = 1'b0;
        cmd_addr  = ADDR_DOUT;
        cmd_wdata = 32'h0;
        wait_rsp(k);
        chk("b2b_first_latency", k, 32'd4);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        chk("b2b_second_setup_psel", {31'd0, PSEL}, 32'd1);
        chk("b2b_second_setup_penable", {31'd0, PENABLE}, 32'd0);
        chk("b2b_second_paddr", PADDR, ADDR_DOUT);
        wait_rsp(k);
        chk("b2b_second_latency", k, 32'd4);

        // Reset during an ACCESS wait state: no response may follow
        @(negedge PCLK);
        cur_waits = 100;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = ADDR_CFG;
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        chk("pre_reset_in_access", {30'd0, PSEL, PENABLE}, 32'd3);
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        chk("mid_reset_psel", {31'd0, PSEL}, 32'd0);
        chk("mid_reset_penable", {31'd0, PENABLE}, 32'd0);
        chk("mid_reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("mid_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        repeat (8) @(negedge PCLK);
        chk("post_reset_idle", {31'd0, busy}, 32'd0);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
